// File: rtl/serialize_ctrl_if.sv
// Decode-to-rename handshake bundle for serialize_ctrl.
// Lane count defaults to DECODE_WIDTH (4 when not defined elsewhere).
`ifndef DECODE_WIDTH
`define DECODE_WIDTH 4
`endif

interface serialize_ctrl_if #(
  parameter int WIDTH = `DECODE_WIDTH
);
  logic             i_squash_vld;
  logic [WIDTH-1:0] i_vld;
  logic [WIDTH-1:0] i_need_serialize;
  logic             i_stall_down;
  logic             i_backend_empty;
  logic             i_serialize_cmt;
  logic [WIDTH-1:0] o_pass;
  logic             o_stall;
  logic             o_busy;
  logic             o_wdog;

  modport master (
    output i_squash_vld, i_vld, i_need_serialize, i_stall_down,
           i_backend_empty, i_serialize_cmt,
    input  o_pass, o_stall, o_busy, o_wdog
  );

  modport slave (
    input  i_squash_vld, i_vld, i_need_serialize, i_stall_down,
           i_backend_empty, i_serialize_cmt,
    output o_pass, o_stall, o_busy, o_wdog
  );
endinterface

// File: rtl/serialize_ctrl.sv
// Serializing-instruction sequencer between decode and rename: drains the backend,
// issues the serialize lane alone, waits for its commit. SERIALIZE_WDOG_EN adds a WAIT_CMT watchdog.
`ifndef DECODE_WIDTH
`define DECODE_WIDTH 4
`endif

module serialize_ctrl #(
  parameter int WIDTH       = `DECODE_WIDTH,
  parameter int WDOG_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,
  serialize_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_ISSUE    = 2'd2,
    ST_WAIT_CMT = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_nx_s;
  logic [WIDTH-1:0] done_r;
  logic [WIDTH-1:0] done_nx_s;
  logic             run_r;

  logic [WIDTH-1:0] pend_s;
  logic [WIDTH-1:0] ser_s;
  logic [WIDTH-1:0] k_oh_s;
  logic [WIDTH-1:0] older_s;
  logic             has_k_s;
  logic             stall_eff_s;
  logic [WIDTH-1:0] pass_s;
  logic             stall_s;

  if (WDOG_CYCLES < 1 || WDOG_CYCLES > 255) begin : g_wdog_range
    $error("serialize_ctrl: WDOG_CYCLES must be within 1..255");
  end

  function automatic logic [WIDTH-1:0] lowest_one(input logic [WIDTH-1:0] vec);
    lowest_one = vec & (~vec + WIDTH'(1'b1));
  endfunction

  // Lane bookkeeping: pending lanes, oldest serialize lane k and the lanes older than it.
  always_comb begin
    pend_s      = bus.i_vld & ~done_r;
    ser_s       = pend_s & bus.i_need_serialize;
    k_oh_s      = lowest_one(ser_s);
    has_k_s     = |ser_s;
    stall_eff_s = bus.i_stall_down | ~run_r;
    if (has_k_s) begin
      older_s = k_oh_s - WIDTH'(1'b1);
    end else begin
      older_s = {WIDTH{1'b0}};
    end
  end

  // Next-state, done-mask and lane-pass decode; squash overrides everything.
  always_comb begin
    state_nx_s = state_r;
    done_nx_s  = done_r;
    pass_s     = {WIDTH{1'b0}};
    stall_s    = 1'b1;
    if (bus.i_squash_vld) begin
      state_nx_s = ST_IDLE;
      done_nx_s  = {WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.i_vld == {WIDTH{1'b0}}) begin
            stall_s   = stall_eff_s;
            done_nx_s = {WIDTH{1'b0}};
          end else if (!has_k_s) begin
            pass_s  = pend_s & {WIDTH{~stall_eff_s}};
            stall_s = stall_eff_s;
            if (!stall_eff_s) begin
              done_nx_s = {WIDTH{1'b0}};
            end else begin
              done_nx_s = done_r;
            end
          end else if (!stall_eff_s) begin
            pass_s     = pend_s & older_s;
            done_nx_s  = done_r | (pend_s & older_s);
            state_nx_s = ST_DRAIN;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end
        // Entry cycle is spent in IDLE, so empty is only sampled from the next cycle on.
        ST_DRAIN: begin
          if (bus.i_backend_empty) begin
            state_nx_s = ST_ISSUE;
          end else begin
            state_nx_s = ST_DRAIN;
          end
        end
        ST_ISSUE: begin
          if (!has_k_s) begin
            state_nx_s = ST_IDLE;
            done_nx_s  = {WIDTH{1'b0}};
          end else if (!stall_eff_s) begin
            pass_s     = k_oh_s;
            done_nx_s  = done_r | k_oh_s;
            state_nx_s = ST_WAIT_CMT;
          end else begin
            state_nx_s = ST_ISSUE;
          end
        end
        ST_WAIT_CMT: begin
          if (bus.i_serialize_cmt) begin
            state_nx_s = ST_IDLE;
          end else begin
            state_nx_s = ST_WAIT_CMT;
          end
        end
        default: begin
          state_nx_s = ST_IDLE;
          done_nx_s  = {WIDTH{1'b0}};
        end
      endcase
    end
  end

  // State, done mask and the run flag that holds lanes back until the first edge after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      done_r  <= {WIDTH{1'b0}};
      run_r   <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      done_r  <= done_nx_s;
      run_r   <= 1'b1;
    end
  end

  assign bus.o_pass  = pass_s;
  assign bus.o_stall = stall_s;
  assign bus.o_busy  = (state_r != ST_IDLE);

`ifdef SERIALIZE_WDOG_EN
  localparam logic [7:0] WDOG_LIMIT = 8'(WDOG_CYCLES);

  logic [7:0] wdog_cnt_r;
  logic [7:0] wdog_cnt_inc_s;
  logic       wdog_r;

  // Saturating increment of the WAIT_CMT cycle count.
  always_comb begin
    if (wdog_cnt_r == 8'hFF) begin
      wdog_cnt_inc_s = wdog_cnt_r;
    end else begin
      wdog_cnt_inc_s = wdog_cnt_r + 8'd1;
    end
  end

  // Counter is held at zero outside WAIT_CMT, so every entry starts from zero; the flag is sticky.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_cnt_r <= 8'd0;
      wdog_r     <= 1'b0;
    end else if (bus.i_squash_vld) begin
      wdog_cnt_r <= 8'd0;
      wdog_r     <= 1'b0;
    end else if (state_r != ST_WAIT_CMT) begin
      wdog_cnt_r <= 8'd0;
      wdog_r     <= wdog_r;
    end else begin
      wdog_cnt_r <= wdog_cnt_inc_s;
      wdog_r     <= wdog_r | (wdog_cnt_inc_s >= WDOG_LIMIT);
    end
  end

  assign bus.o_wdog = wdog_r;
`else
  assign bus.o_wdog = 1'b0;
`endif

endmodule

// File: tb/tb_serialize_ctrl.sv
// Directed self-checking bench for serialize_ctrl (WIDTH=4), hand-computed expectations.
module tb_serialize_ctrl;
  localparam int W = 4;
`ifdef SERIALIZE_WDOG_EN
  localparam logic WDOG_EXP = 1'b1;
`else
  localparam logic WDOG_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  serialize_ctrl_if #(.WIDTH(W)) bus();

  serialize_ctrl #(.WIDTH(W), .WDOG_CYCLES(255)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %b expected %b", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] pass, input logic stall, input logic busy);
    #1;
    check_eq({tag, ".pass"}, bus.o_pass, pass);
    check_eq({tag, ".stall"}, {3'b000, bus.o_stall}, {3'b000, stall});
    check_eq({tag, ".busy"}, {3'b000, bus.o_busy}, {3'b000, busy});
  endtask

  task automatic set_in(input logic [3:0] vld, input logic [3:0] need, input logic stall, input logic empty);
    bus.i_vld            = vld;
    bus.i_need_serialize = need;
    bus.i_stall_down     = stall;
    bus.i_backend_empty  = empty;
  endtask

  initial begin
    rst                 = 1'b0;
    bus.i_squash_vld    = 1'b0;
    bus.i_serialize_cmt = 1'b0;
    set_in(4'b1111, 4'b0000, 1'b0, 1'b0);
    #12;
    expect_out("reset", 4'b0000, 1'b1, 1'b0);
    check_eq("reset.wdog", {3'b000, bus.o_wdog}, 4'b0000);
    #9;
    rst = 1'b1;
    #1;
    check_eq("pre_first_edge.pass", bus.o_pass, 4'b0000);
    tick();
    expect_out("no_ser", 4'b1111, 1'b0, 1'b0);

    // lane 2 serializes, lane 3 follows after commit
    tick();
    set_in(4'b1111, 4'b0100, 1'b0, 1'b1);
    expect_out("l2_c0", 4'b0011, 1'b1, 1'b0);
    tick(); expect_out("l2_drain", 4'b0000, 1'b1, 1'b1);
    tick(); expect_out("l2_issue", 4'b0100, 1'b1, 1'b1);
    tick(); expect_out("l2_wait", 4'b0000, 1'b1, 1'b1);
    bus.i_serialize_cmt = 1'b1;
    expect_out("l2_cmt", 4'b0000, 1'b1, 1'b1);
    tick();
    bus.i_serialize_cmt = 1'b0;
    expect_out("l2_young", 4'b1000, 1'b0, 1'b0);
    tick();
    set_in(4'b0000, 4'b0000, 1'b0, 1'b0);
    expect_out("vld_zero", 4'b0000, 1'b0, 1'b0);

    // lane 0 serializes behind a busy backend
    set_in(4'b0001, 4'b0001, 1'b0, 1'b0);
    expect_out("l0_idle", 4'b0000, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      expect_out("l0_drain", 4'b0000, 1'b1, 1'b1);
    end
    bus.i_backend_empty = 1'b1;
    expect_out("l0_empty_rise", 4'b0000, 1'b1, 1'b1);
    tick(); expect_out("l0_issue", 4'b0001, 1'b1, 1'b1);
    tick(); expect_out("l0_wait", 4'b0000, 1'b1, 1'b1);

    // watchdog: commit never arrives
    for (int i = 0; i < 254; i++) tick();
    check_eq("wdog_254", {3'b000, bus.o_wdog}, 4'b0000);
    tick();
    check_eq("wdog_255", {3'b000, bus.o_wdog}, {3'b000, WDOG_EXP});

    // squash in WAIT_CMT
    bus.i_squash_vld = 1'b1;
    #1;
    check_eq("squash.pass", bus.o_pass, 4'b0000);
    tick();
    bus.i_squash_vld = 1'b0;
    set_in(4'b1111, 4'b0000, 1'b0, 1'b0);
    expect_out("post_squash", 4'b1111, 1'b0, 1'b0);
    check_eq("post_squash.wdog", {3'b000, bus.o_wdog}, 4'b0000);

    // rename stall while in ISSUE
    tick();
    set_in(4'b0010, 4'b0010, 1'b0, 1'b1);
    expect_out("st_idle", 4'b0000, 1'b1, 1'b0);
    tick(); expect_out("st_drain", 4'b0000, 1'b1, 1'b1);
    tick();
    bus.i_stall_down = 1'b1;
    expect_out("st_issue_hold", 4'b0000, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick();
      expect_out("st_issue_hold", 4'b0000, 1'b1, 1'b1);
    end
    tick();
    bus.i_stall_down = 1'b0;
    expect_out("st_issue_go", 4'b0010, 1'b1, 1'b1);
    tick(); expect_out("st_wait", 4'b0000, 1'b1, 1'b1);
    bus.i_serialize_cmt = 1'b1;
    tick();
    bus.i_serialize_cmt = 1'b0;
    expect_out("st_idle_done", 4'b0000, 1'b0, 1'b0);

    // serialize lane found while rename stalls in IDLE
    tick();
    set_in(4'b1111, 4'b1000, 1'b1, 1'b0);
    expect_out("idle_hold", 4'b0000, 1'b1, 1'b0);
    tick(); expect_out("idle_hold2", 4'b0000, 1'b1, 1'b0);
    bus.i_stall_down = 1'b0;
    expect_out("idle_go", 4'b0111, 1'b1, 1'b0);
    tick(); expect_out("idle_drain", 4'b0000, 1'b1, 1'b1);
    bus.i_squash_vld = 1'b1;
    #1;
    check_eq("drain_squash.pass", bus.o_pass, 4'b0000);
    tick();
    bus.i_squash_vld = 1'b0;
    set_in(4'b0000, 4'b0000, 1'b0, 1'b1);
    expect_out("drain_squash_idle", 4'b0000, 1'b0, 1'b0);

    // two serialize lanes in one group, each with its own full pass
    tick();
    set_in(4'b1111, 4'b0101, 1'b0, 1'b1);
    expect_out("two_c0", 4'b0000, 1'b1, 1'b0);
    tick(); expect_out("two_drain0", 4'b0000, 1'b1, 1'b1);
    tick(); expect_out("two_issue0", 4'b0001, 1'b1, 1'b1);
    tick(); expect_out("two_wait0", 4'b0000, 1'b1, 1'b1);
    bus.i_serialize_cmt = 1'b1;
    tick();
    bus.i_serialize_cmt = 1'b0;
    expect_out("two_idle1", 4'b0010, 1'b1, 1'b0);
    tick(); expect_out("two_drain1", 4'b0000, 1'b1, 1'b1);
    tick(); expect_out("two_issue1", 4'b0100, 1'b1, 1'b1);
    tick(); expect_out("two_wait1", 4'b0000, 1'b1, 1'b1);
    bus.i_serialize_cmt = 1'b1;
    tick();
    bus.i_serialize_cmt = 1'b0;
    expect_out("two_idle2", 4'b1000, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/serialize_ctrl.md
SERIALIZE_CTRL -- requirements
Module: serialize_ctrl

Interface
REQ-001 Parameter WIDTH, default `DECODE_WIDTH (4), number of decode lanes sequenced.
REQ-002 Parameter WDOG_CYCLES, default 255, watchdog limit in cycles (used only under REQ-030).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 i_squash_vld  input  1  backend squash.
REQ-006 i_vld  input  WIDTH  decoded lane valid (decinfo group held stable while o_stall=1).
REQ-007 i_need_serialize  input  WIDTH  per-lane need_serialize flag.
REQ-008 i_stall_down  input  1  rename stall; no lane may pass while 1.
REQ-009 i_backend_empty  input  1  ROB and rename/dispatch hold no instructions.
REQ-010 i_serialize_cmt  input  1  serialized instruction has committed.
REQ-011 o_pass  output  WIDTH  lanes forwarded to rename this cycle.
REQ-012 o_stall  output  1  hold current decode group (to decode i_stall).
REQ-013 o_busy  output  1  state != IDLE.
REQ-014 o_wdog  output  1  watchdog expired (REQ-030 only; else tied 0).

Function
REQ-015 States IDLE, DRAIN, ISSUE, WAIT_CMT; 2-bit state plus WIDTH-bit done mask of lanes already passed from the current group.
REQ-016 pend = i_vld & ~done; k = lowest index in pend with i_need_serialize set.
REQ-017 IDLE, no k: o_pass = pend & {WIDTH{~i_stall_down}}; o_stall = i_stall_down; if not stalled, done cleared.
REQ-018 IDLE, k exists: o_pass = pend lanes below k, gated by ~i_stall_down; o_stall = 1; if not stalled, those lanes set in done and next state DRAIN.
REQ-019 IDLE, k exists and i_stall_down=1: o_pass = 0, state and done unchanged.
REQ-020 DRAIN: o_pass = 0, o_stall = 1; go to ISSUE on first cycle with i_backend_empty=1, never in the same cycle as DRAIN entry.
REQ-021 ISSUE: o_pass = lane k only, gated by ~i_stall_down; o_stall = 1; when passed, set done[k], go to WAIT_CMT.
REQ-022 WAIT_CMT: o_pass = 0, o_stall = 1; on i_serialize_cmt=1 go to IDLE; younger lanes then resolved per REQ-016..REQ-018 starting next cycle.
REQ-023 Consecutive serialize lanes each take a full DRAIN/ISSUE/WAIT_CMT pass.
REQ-024 i_squash_vld=1 in any state: o_pass = 0 that cycle, next state IDLE, done cleared; wins over every other event.
REQ-025 i_vld = 0: o_pass = 0, o_stall = i_stall_down, done cleared.
REQ-026 Latency: non-serialized lanes pass combinationally in the cycle presented; serialized lane passes no earlier than 2 cycles after its older lanes.

Reset
REQ-027 While rst low: state IDLE, done = 0, watchdog counter = 0; o_pass = 0, o_stall = 1, o_busy = 0, o_wdog = 0.
REQ-028 After rst rises, first edge evaluates IDLE rules; no lane passes before then.

Configuration
REQ-029 Macro SERIALIZE_WDOG_EN selects the watchdog.
REQ-030 Defined: 8-bit counter clears on WAIT_CMT entry, increments each WAIT_CMT cycle, saturates; o_wdog = 1 when count reaches WDOG_CYCLES and stays 1 until squash or reset; FSM behaviour unchanged.
REQ-031 Undefined: no counter, o_wdog tied 0.

Verification
REQ-032 WIDTH=4, i_vld=1111, no serialize, i_stall_down=0 -> o_pass=1111, o_stall=0 same cycle.
REQ-033 i_vld=1111, i_need_serialize=0100, backend empty -> c0 o_pass=0011; DRAIN; ISSUE o_pass=0100; after i_serialize_cmt, next IDLE o_pass=1000, o_stall=0.
REQ-034 Serialize on lane 0, i_backend_empty=0 for 10 cycles -> o_pass=0 and o_stall=1 throughout; lane 0 passes in the ISSUE cycle after empty rises.
REQ-035 i_squash_vld=1 during WAIT_CMT -> o_pass=0 that cycle, o_busy=0 next cycle, new group with no serialize passes fully.
REQ-036 i_stall_down=1 in ISSUE for 3 cycles -> o_pass=0, state stays ISSUE; lane passes the cycle stall drops.
REQ-037 SERIALIZE_WDOG_EN defined, WDOG_CYCLES=255, no commit -> o_wdog rises after 255 WAIT_CMT cycles; undefined -> o_wdog stays 0.
